// File: rtl/per_req_slice_pe.sv
// Registered request/response slice ahead of a peripheral target: 2-entry request buffer,
// one response register stage, and an in-flight counter that throttles the upstream grant.
module per_req_slice_pe #(
  parameter int ID_WIDTH        = 20,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     data_req_i,
  input  logic [ADDR_WIDTH-1:0]                    data_add_i,
  input  logic                                     data_wen_i,
  input  logic [5:0]                               data_atop_i,
  input  logic [DATA_WIDTH-1:0]                    data_wdata_i,
  input  logic [BE_WIDTH-1:0]                      data_be_i,
  input  logic [ID_WIDTH-1:0]                      data_ID_i,
  output logic                                     data_gnt_o,
  output logic                                     data_req_o,
  output logic [ADDR_WIDTH-1:0]                    data_add_o,
  output logic                                     data_wen_o,
  output logic [5:0]                               data_atop_o,
  output logic [DATA_WIDTH-1:0]                    data_wdata_o,
  output logic [BE_WIDTH-1:0]                      data_be_o,
  output logic [ID_WIDTH-1:0]                      data_ID_o,
  input  logic                                     data_gnt_i,
  input  logic                                     data_r_valid_i,
  input  logic [ID_WIDTH-1:0]                      data_r_ID_i,
  input  logic [DATA_WIDTH-1:0]                    data_r_rdata_i,
  input  logic                                     data_r_opc_i,
  output logic                                     data_r_valid_o,
  output logic [ID_WIDTH-1:0]                      data_r_ID_o,
  output logic [DATA_WIDTH-1:0]                    data_r_rdata_o,
  output logic                                     data_r_opc_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     proto_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [5:0]            atop;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic [ID_WIDTH-1:0]   id;
  } req_t;

  req_t          r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_cnt;
  logic [CW-1:0] r_out;
  logic          r_perr;

  req_t w_in;
  req_t w_head;
  logic w_push;
  logic w_pop;

  // Grant comes from registered state only (rst gating keeps it low during reset),
  // so the upstream arbiter tree never sees a path from the downstream grant.
  assign data_gnt_o = ~rst & (r_cnt != 2'd2) & (r_out < MAX_C);
  assign data_req_o = (r_cnt != 2'd0);
  assign w_push     = data_req_i & data_gnt_o;
  assign w_pop      = data_req_o & data_gnt_i;

  assign w_in   = {data_add_i, data_wen_i, data_atop_i, data_wdata_i, data_be_i, data_ID_i};
  assign w_head = r_mem[r_rptr];
  assign {data_add_o, data_wen_o, data_atop_o, data_wdata_o, data_be_o, data_ID_o} = w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_in;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A response with nothing in flight is flagged and never underflows the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_perr <= 1'b0;
    end else if (w_push && !data_r_valid_i) begin
      r_out <= r_out + CW'(1);
    end else if (!w_push && data_r_valid_i) begin
      if (r_out == '0) begin
        r_perr <= 1'b1;
      end else begin
        r_out <= r_out - CW'(1);
      end
    end
  end

  assign outstanding_o = r_out;
  assign proto_err_o   = r_perr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r_valid_o <= 1'b0;
      data_r_ID_o    <= '0;
      data_r_rdata_o <= '0;
      data_r_opc_o   <= 1'b0;
    end else begin
      data_r_valid_o <= data_r_valid_i;
      data_r_ID_o    <= data_r_ID_i;
      data_r_rdata_o <= data_r_rdata_i;
      data_r_opc_o   <= data_r_opc_i;
    end
  end

endmodule
